// File: rtl/zap_wb_ram_slave.sv
// -----------------------------------------------------------------------------
// zap_wb_ram_slave
//
// Wishbone B4 responder backed by a word-organised RAM. It serves classic
// single transfers and linear incrementing bursts (CTI 010 ... 111), with a
// configurable number of wait states before the first ack of every
// transaction so that master stall paths get exercised.
//
// Parameters
//   DEPTH_WORDS : RAM depth in 32-bit words (power of two, at least 2). The
//                 word index is i_wb_adr[log2(DEPTH_WORDS)+1:2]; upper address
//                 bits are ignored, so the RAM aliases through the space.
//   WAIT_STATES : extra cycles (0..15) before the first ack of a transaction.
//
// Ports
//   i_clk      : clock, all logic on the rising edge
//   i_reset_n  : asynchronous active-low reset
//   i_wb_cyc   : bus cycle valid
//   i_wb_stb   : strobe / beat request
//   i_wb_adr   : byte address, bits [1:0] ignored
//   i_wb_we    : 1 = write
//   i_wb_sel   : byte lane enables, sel[n] covers dat[8n+7:8n]
//   i_wb_dat   : write data
//   i_wb_cti   : 000 classic, 010 incrementing burst, 111 end of burst
//   i_wb_bte   : burst type, only linear is supported (value ignored)
//   o_wb_ack   : beat acknowledge (ack_r gated by cyc & stb)
//   o_wb_dat   : read data, valid when o_wb_ack=1 and i_wb_we=0
// -----------------------------------------------------------------------------
module zap_wb_ram_slave #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic [31:0] i_wb_adr,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_dat,
    input  logic [2:0]  i_wb_cti,
    input  logic [1:0]  i_wb_bte,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_dat
);

    localparam int              AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]      WS_INIT = 4'(WAIT_STATES);
    localparam logic [AW-1:0]   IDX_ONE = AW'(32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_XFER = 2'b10
    } state_t;

    state_t         state_r;
    logic [3:0]     wait_cnt_r;
    logic           ack_r;
    logic           burst_r;
    logic [AW-1:0]  idx_r;
    logic [31:0]    rd_dat_r;
    logic [31:0]    mem_r [DEPTH_WORDS];

    logic           req_s;
    logic           beat_s;
    logic           burst_next_s;
    logic           wr_en_s;
    logic           load_s;
    logic [AW-1:0]  adr_idx_s;
    logic [AW-1:0]  rd_idx_s;
    logic [31:0]    rd_word_s;
    logic           unused_s;

    // Merge new write data into an existing word, lane by lane.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    assign req_s        = i_wb_cyc & i_wb_stb;
    assign beat_s       = ack_r & i_wb_cyc & i_wb_stb;
    assign adr_idx_s    = i_wb_adr[AW+1:2];
    assign burst_next_s = burst_r & (i_wb_cti == 3'b010);
    assign wr_en_s      = (state_r == ST_XFER) & beat_s & i_wb_we;
    assign rd_word_s    = mem_r[rd_idx_s];
    assign o_wb_ack     = beat_s;
    assign o_wb_dat     = rd_dat_r;
    assign unused_s     = ^{i_wb_bte, i_wb_adr[1:0], i_wb_adr[31:AW+2]};

    // Read-port address and load strobe: read data is captured on the edge
    // that raises ack_r, and on every completed burst beat for the next word.
    always_comb begin
        load_s   = 1'b0;
        rd_idx_s = idx_r;
        case (state_r)
            ST_IDLE: begin
                rd_idx_s = adr_idx_s;
                load_s   = req_s & (WS_INIT == 4'd0);
            end
            ST_WAIT: begin
                rd_idx_s = idx_r;
                load_s   = i_wb_cyc & (wait_cnt_r == 4'd1);
            end
            ST_XFER: begin
                rd_idx_s = idx_r + IDX_ONE;
                load_s   = beat_s & burst_next_s;
            end
            default: begin
                rd_idx_s = idx_r;
                load_s   = 1'b0;
            end
        endcase
    end

    // RAM write port; contents are intentionally left unreset.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem_r[idx_r] <= merge_lanes(mem_r[idx_r], i_wb_dat, i_wb_sel);
        end
    end

    // Transaction FSM: request capture, wait-state countdown, beat sequencing.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            ack_r      <= 1'b0;
            burst_r    <= 1'b0;
            idx_r      <= {AW{1'b0}};
            rd_dat_r   <= 32'd0;
        end else begin
            if (load_s) begin
                rd_dat_r <= rd_word_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        idx_r   <= adr_idx_s;
                        burst_r <= (i_wb_cti == 3'b010);
                        if (WS_INIT == 4'd0) begin
                            state_r <= ST_XFER;
                            ack_r   <= 1'b1;
                        end else begin
                            state_r    <= ST_WAIT;
                            wait_cnt_r <= WS_INIT;
                            ack_r      <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    // A dropped stb does not pause the count; only cyc aborts.
                    if (!i_wb_cyc) begin
                        state_r    <= ST_IDLE;
                        ack_r      <= 1'b0;
                        wait_cnt_r <= 4'd0;
                    end else if (wait_cnt_r == 4'd1) begin
                        state_r    <= ST_XFER;
                        ack_r      <= 1'b1;
                        wait_cnt_r <= 4'd0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ST_XFER: begin
                    if (!i_wb_cyc) begin
                        state_r <= ST_IDLE;
                        ack_r   <= 1'b0;
                    end else if (beat_s) begin
                        if (burst_next_s) begin
                            // idx wraps naturally at the RAM depth
                            idx_r <= idx_r + IDX_ONE;
                        end else begin
                            state_r <= ST_IDLE;
                            ack_r   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/zap_wb_ram_slave.md
Name: zap_wb_ram_slave

Overview:
- Wishbone B4 responder: the target end of the ZAP external bus (cyc/stb/adr/we/sel/dat/cti/bte in; ack/dat out).
- Contains a word-organised RAM and serves classic single transfers and linear incrementing bursts (CTI 010 ... 111).
- Used as the memory model in core-level benches and as on-chip boot/scratch RAM behind the store-buffer adapter.
- Configurable first-beat wait states so the master's stall paths get exercised.

Parameters:
DEPTH_WORDS, 4096, RAM depth in 32-bit words; must be a power of two; word index = i_wb_adr[log2(DEPTH_WORDS)+1:2], upper bits ignored (aliasing).
WAIT_STATES, 1, extra cycles (0..15) inserted before the first ack of every transaction.

Ports:
i_clk  in  1  clock, all logic on rising edge.
i_reset_n  in  1  asynchronous active-low reset.
i_wb_cyc  in  1  bus cycle valid.
i_wb_stb  in  1  strobe / beat request.
i_wb_adr  in  32  byte address; bits [1:0] ignored.
i_wb_we  in  1  1 = write.
i_wb_sel  in  4  byte lane enables; sel[n] covers dat[8n+7:8n].
i_wb_dat  in  32  write data.
i_wb_cti  in  3  000 classic, 010 incrementing burst, 111 end of burst; any other value is treated as 000.
i_wb_bte  in  2  burst type; only 00 (linear) is supported and the value is ignored.
o_wb_ack  out  1  beat acknowledge.
o_wb_dat  out  32  read data, valid when o_wb_ack=1 and i_wb_we=0.

Behaviour:
- Reset: i_reset_n low clears, asynchronously, state=IDLE, wait counter=0, ack_q=0, o_wb_dat=0. RAM contents are not reset. Reset asserted mid-transaction: the transaction is dropped and no write occurs after the reset edge.
- Ack gating: o_wb_ack = ack_q & i_wb_cyc & i_wb_stb, combinational. A beat completes in a cycle where o_wb_ack=1.
- FSM states: IDLE, WAIT, XFER.
- IDLE:
  - cyc&stb sampled high: latch word index from i_wb_adr, latch mode (burst if cti=010, else single).
  - WAIT_STATES=0: go to XFER and set ack_q, so ack appears the next cycle.
  - WAIT_STATES>0: go to WAIT with counter=WAIT_STATES.
  - First-beat latency is therefore WAIT_STATES+1 cycles after the request is sampled.
- WAIT: counter decrements each cycle. On reaching 1, go to XFER and set ack_q. i_wb_stb low during WAIT does not stop the count; ack is simply masked until stb returns.
- XFER, per completed beat:
  - Write beat: RAM[idx] byte lanes with sel=1 take i_wb_dat; other lanes unchanged.
  - Read data: o_wb_dat is registered from RAM at the same edge that sets ack_q, and re-registered from RAM[idx+1] at each completed burst beat. Read data is therefore valid in the ack cycle with zero inter-beat wait.
  - Single mode, or cti=111 on the completed beat: clear ack_q and go to IDLE. A new request is accepted only from the following cycle.
  - Burst mode and cti=010: idx <= idx+1 (wraps modulo DEPTH_WORDS) and ack_q stays 1, giving back-to-back acks.
- Master stall mid-burst (stb low, cyc high): no beat completes; idx, o_wb_dat and ack_q hold; the burst resumes when stb returns.
- Abort: i_wb_cyc low in WAIT or XFER goes to IDLE next cycle with ack_q=0. No write occurs in a cycle where cyc=0.
- The slave never asserts ack with cyc or stb low.
- Burst addressing: the internal idx is authoritative; i_wb_adr is sampled only on the first beat.
- Read-after-write, same address, back-to-back classic transfers: the read returns the newly written data, since the write completes before the read's RAM access edge.

Test Plan:
- Classic write then read: write 0xDEADBEEF to 0x10 with sel=1111, then read 0x10 -> ack WAIT_STATES+1 cycles after each request, exactly one ack cycle each, o_wb_dat=0xDEADBEEF.
- Byte lanes: after 0xDEADBEEF at 0x10, write 0x0000AA00 with sel=0010, then read -> 0xDEADAAEF.
- Burst read: preload words 0x40..0x7C with their addresses; 16-beat read from 0x40 (cti 010 x15 then 111) -> acks on 16 consecutive cycles, data 0x40, 0x44, ... 0x7C, slave back in IDLE the cycle after the last ack.
- Master stall: 8-beat burst write with stb dropped for 3 cycles after beat 3 -> no ack while stb is low, beats 4..8 land at consecutive words, readback matches.
- Wrap, abort, reset:
  - DEPTH_WORDS=16, 4-beat burst from 0x38 -> beats hit words 14, 15, 0, 1.
  - cyc dropped in WAIT during a write -> no ack, memory unchanged.
  - i_reset_n pulsed low mid-burst -> o_wb_ack=0 immediately, o_wb_dat=0, next request served normally.
- WAIT_STATES=0 build: classic read ack on the cycle after the request is sampled; 4-beat burst acked on 4 consecutive cycles.
